shift_left2: RTL and testbench
==============================

Name: shift_left2

Overview:
- Shift-left-by-two unit for the EX stage of the MIPS pipeline. Turns a sign-extended word offset into a byte offset for branch-target addition.
- Provides two result paths:
  - a zero-latency combinational result for the branch adder;
  - a one-cycle registered copy with valid and overflow status for pipelined or debug consumers.

Parameters:
- WIDTH, 32, data width in bits (must be > SHIFT).
- SHIFT, 2, constant left-shift amount (must be >= 1 and < WIDTH).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset.
- genericInput  input  WIDTH  value to shift.
- inValid  input  1  genericInput is valid this cycle (registered path only).
- clearSticky  input  1  synchronous clear of stickyOverflow.
- shiftedGenericOutput  output  WIDTH  combinational result, genericInput << SHIFT.
- lostBits  output  SHIFT  combinational, genericInput[WIDTH-1 -: SHIFT] (bits shifted out).
- overflow  output  1  combinational, OR of lostBits.
- regShiftedOutput  output  WIDTH  registered result.
- regValid  output  1  registered inValid.
- regOverflow  output  1  registered overflow, qualified by inValid.
- stickyOverflow  output  1  set once any valid input overflows.

Behaviour:
- Combinational path:
  - shiftedGenericOutput = {genericInput[WIDTH-SHIFT-1:0], SHIFT'b0}; the low SHIFT bits are always 0.
  - Zero latency; no dependence on clk or rst_n. It must settle within the same time step as an input change and must be valid while rst_n is low.
  - Pure logical shift: no sign preservation. Bits shifted out the top are reported on lostBits and overflow and are otherwise discarded.
- Registered path, on each rising clk edge with rst_n high:
  - regValid <= inValid.
  - When inValid = 1: regShiftedOutput <= shiftedGenericOutput and regOverflow <= overflow.
  - When inValid = 0: regShiftedOutput holds its value and regOverflow <= 0.
- stickyOverflow, on the same edge:
  - clearSticky = 1: clears to 0. This has priority over a simultaneous set, i.e. inValid & overflow in the same cycle.
  - Otherwise it is set to 1 when inValid & overflow, else it holds.
- Reset:
  - rst_n low asynchronously forces regShiftedOutput = 0, regValid = 0, regOverflow = 0 and stickyOverflow = 0, independent of clk.
  - Release is synchronised by the user; the first capture happens at the first rising edge after rst_n goes high.
  - Reset asserted mid-stream discards the captured value immediately.
- Boundaries:
  - Input all ones produces output all ones except the low SHIFT bits, with overflow = 1.
  - Input 0 produces 0, overflow = 0.
  - Input X/Z is not defined; the bench drives known values only.
- No internal state other than the four registers above. No handshake back-pressure: the registered path accepts every cycle.

Test Plan:
- genericInput = 0x00000000 -> shiftedGenericOutput = 0x00000000, lostBits = 00, overflow = 0, all within 1 time unit.
- genericInput = 0x00000001 -> 0x00000004, overflow = 0.
- genericInput = 0xFFFFFFFF -> 0xFFFFFFFC, lostBits = 11, overflow = 1.
- genericInput = 0x20000000 -> 0x80000000, overflow = 0; genericInput = 0x40000000 -> 0x00000000, lostBits = 01, overflow = 1.
- Registered and sticky flow:
  1. With rst_n high, drive inValid = 1 and 0xFFFFFFFF for one edge -> regShiftedOutput = 0xFFFFFFFC, regValid = 1, regOverflow = 1, stickyOverflow = 1.
  2. Drive inValid = 0 for the next edge -> regValid = 0, regOverflow = 0, value held, stickyOverflow stays 1.
  3. Pulse clearSticky together with an overflowing valid input -> stickyOverflow = 0.
- Drop rst_n between clock edges -> all registered outputs become 0 immediately without a clock edge; the combinational output still tracks the input (0x00000001 -> 0x00000004) during reset.

Source files
------------

// File: rtl/shift_left2.sv
// Shift-left-by-SHIFT unit for the EX stage: a zero-latency combinational result
// for the branch adder plus a one-cycle registered copy with valid/overflow status.
module shift_left2 #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] genericInput,
    input  logic             inValid,
    input  logic             clearSticky,
    output logic [WIDTH-1:0] shiftedGenericOutput,
    output logic [SHIFT-1:0] lostBits,
    output logic             overflow,
    output logic [WIDTH-1:0] regShiftedOutput,
    output logic             regValid,
    output logic             regOverflow,
    output logic             stickyOverflow
);

    // Handshake: inValid is a qualifier only; there is no ready, so every cycle is
    // accepted. regValid is inValid delayed by one edge; regShiftedOutput is only
    // meaningful while regValid is high and holds its last captured value otherwise.

    logic [WIDTH-1:0] reg_data_d, reg_data_q;
    logic             reg_valid_d, reg_valid_q;
    logic             reg_ovf_d, reg_ovf_q;
    logic             sticky_d, sticky_q;

    // Pure logical shift; the bits pushed out the top are only reported, never kept.
    always_comb begin
        shiftedGenericOutput = {genericInput[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        lostBits             = genericInput[WIDTH-1 -: SHIFT];
        overflow             = |lostBits;
    end

    always_comb begin
        reg_data_d  = reg_data_q;
        reg_valid_d = inValid;
        reg_ovf_d   = inValid & overflow;
        sticky_d    = sticky_q;
        if (inValid) begin
            reg_data_d = shiftedGenericOutput;
        end
        // Clear wins over a set arriving in the same cycle.
        if (clearSticky) begin
            sticky_d = 1'b0;
        end else if (inValid && overflow) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_data_q  <= '0;
            reg_valid_q <= 1'b0;
            reg_ovf_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            reg_data_q  <= reg_data_d;
            reg_valid_q <= reg_valid_d;
            reg_ovf_q   <= reg_ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign regShiftedOutput = reg_data_q;
    assign regValid         = reg_valid_q;
    assign regOverflow      = reg_ovf_q;
    assign stickyOverflow   = sticky_q;

endmodule

// File: tb/tb_shift_left2.sv
// Self-checking bench for shift_left2: directed boundary cases, a registered/sticky
// flow, a randomized stream against an arithmetic reference, and async reset.
module tb_shift_left2;

    localparam int W = 32;
    localparam int S = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] genericInput;
    logic         inValid;
    logic         clearSticky;
    logic [W-1:0] shiftedGenericOutput;
    logic [S-1:0] lostBits;
    logic         overflow;
    logic [W-1:0] regShiftedOutput;
    logic         regValid;
    logic         regOverflow;
    logic         stickyOverflow;

    int checks;
    int failures;

    // Reference state for the registered path.
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovf;
    logic         m_sticky;

    shift_left2 #(.WIDTH(W), .SHIFT(S)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .genericInput         (genericInput),
        .inValid              (inValid),
        .clearSticky          (clearSticky),
        .shiftedGenericOutput (shiftedGenericOutput),
        .lostBits             (lostBits),
        .overflow             (overflow),
        .regShiftedOutput     (regShiftedOutput),
        .regValid             (regValid),
        .regOverflow          (regOverflow),
        .stickyOverflow       (stickyOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by 2**S modulo 2**W; lost bits are the quotient by 2**(W-S).
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v);
        longint unsigned p;
        p = (longint'(v) * (longint'(1) << S)) % (longint'(1) << W);
        return p[W-1:0];
    endfunction

    function automatic logic [S-1:0] ref_lost(input logic [W-1:0] v);
        longint unsigned q;
        q = longint'(v) / (longint'(1) << (W - S));
        return q[S-1:0];
    endfunction

    task automatic check_comb(input string name, input logic [W-1:0] v);
        logic [W-1:0] e_out;
        logic [S-1:0] e_lost;
        logic         e_ovf;
        e_out  = ref_shift(v);
        e_lost = ref_lost(v);
        e_ovf  = (e_lost != 0);
        checks++;
        if (shiftedGenericOutput !== e_out) begin
            failures++;
            $display("FAIL %s shifted in=%h got=%h exp=%h", name, v, shiftedGenericOutput, e_out);
        end
        checks++;
        if (lostBits !== e_lost) begin
            failures++;
            $display("FAIL %s lostBits in=%h got=%b exp=%b", name, v, lostBits, e_lost);
        end
        checks++;
        if (overflow !== e_ovf) begin
            failures++;
            $display("FAIL %s overflow in=%h got=%b exp=%b", name, v, overflow, e_ovf);
        end
    endtask

    task automatic check_regs(input string name);
        checks++;
        if (regShiftedOutput !== m_data) begin
            failures++;
            $display("FAIL %s regShiftedOutput got=%h exp=%h", name, regShiftedOutput, m_data);
        end
        checks++;
        if (regValid !== m_valid) begin
            failures++;
            $display("FAIL %s regValid got=%b exp=%b", name, regValid, m_valid);
        end
        checks++;
        if (regOverflow !== m_ovf) begin
            failures++;
            $display("FAIL %s regOverflow got=%b exp=%b", name, regOverflow, m_ovf);
        end
        checks++;
        if (stickyOverflow !== m_sticky) begin
            failures++;
            $display("FAIL %s stickyOverflow got=%b exp=%b", name, stickyOverflow, m_sticky);
        end
    endtask

    // Apply one cycle of inputs, advance the reference, then sample after the edge.
    task automatic drive_cycle(input logic [W-1:0] v, input logic vld, input logic clr);
        logic e_ovf;
        genericInput = v;
        inValid      = vld;
        clearSticky  = clr;
        @(posedge clk);
        #1;
        e_ovf   = vld && (ref_lost(v) != 0);
        m_valid = vld;
        m_ovf   = e_ovf;
        if (vld) m_data = ref_shift(v);
        if (clr) m_sticky = 1'b0;
        else if (e_ovf) m_sticky = 1'b1;
    endtask

    task automatic test_reset();
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_sticky = 1'b0;
        genericInput = 32'h0000_0001;
        #1;
        check_comb("reset_comb", genericInput);
        check_regs("reset_regs");
        // Release away from the active edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs("after_release");
    endtask

    task automatic test_comb_directed();
        logic [W-1:0] vec[6];
        vec[0] = 32'h0000_0000;
        vec[1] = 32'h0000_0001;
        vec[2] = 32'hFFFF_FFFF;
        vec[3] = 32'h2000_0000;
        vec[4] = 32'h4000_0000;
        vec[5] = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin
            genericInput = vec[i];
            #1;
            check_comb("comb_directed", vec[i]);
        end
        // Literal expectations for the documented boundaries.
        genericInput = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (shiftedGenericOutput !== 32'hFFFF_FFFC || lostBits !== 2'b11 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL comb_all_ones got=%h/%b/%b exp=fffffffc/11/1", shiftedGenericOutput, lostBits, overflow);
        end
        genericInput = 32'h4000_0000;
        #1;
        checks++;
        if (shiftedGenericOutput !== 32'h0000_0000 || lostBits !== 2'b01 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL comb_bit30 got=%h/%b/%b exp=00000000/01/1", shiftedGenericOutput, lostBits, overflow);
        end
    endtask

    task automatic test_registered_flow();
        @(negedge clk);
        drive_cycle(32'hFFFF_FFFF, 1'b1, 1'b0);
        check_regs("flow_capture");
        checks++;
        if (regShiftedOutput !== 32'hFFFF_FFFC || stickyOverflow !== 1'b1) begin
            failures++;
            $display("FAIL flow_capture_lit got=%h/%b exp=fffffffc/1", regShiftedOutput, stickyOverflow);
        end
        drive_cycle(32'h1234_5678, 1'b0, 1'b0);
        check_regs("flow_hold");
        drive_cycle(32'h4000_0000, 1'b1, 1'b1);
        check_regs("flow_clear_priority");
        checks++;
        if (stickyOverflow !== 1'b0) begin
            failures++;
            $display("FAIL flow_clear_lit sticky got=%b exp=0", stickyOverflow);
        end
    endtask

    task automatic test_random_stream(input int n);
        logic [W-1:0] v;
        logic         vld;
        logic         clr;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            // Bias half the inputs into the non-overflowing range.
            if ($urandom_range(0, 1) == 0) v[W-1 -: S] = '0;
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            genericInput = v;
            #1;
            check_comb("rand_comb", v);
            drive_cycle(v, vld, clr);
            check_regs("rand_regs");
        end
        inValid     = 1'b0;
        clearSticky = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Consecutive valid overflowing then non-overflowing captures.
        drive_cycle(32'hC000_0003, 1'b1, 1'b0);
        check_regs("b2b_first");
        drive_cycle(32'h0000_0005, 1'b1, 1'b0);
        check_regs("b2b_second");
        drive_cycle(32'h0000_0006, 1'b1, 1'b0);
        check_regs("b2b_third");
    endtask

    task automatic test_async_reset();
        drive_cycle(32'hFFFF_FFFF, 1'b1, 1'b0);
        check_regs("async_pre");
        inValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_sticky = 1'b0;
        check_regs("async_mid_cycle");
        genericInput = 32'h0000_0001;
        #1;
        check_comb("async_comb", 32'h0000_0001);
        checks++;
        if (shiftedGenericOutput !== 32'h0000_0004) begin
            failures++;
            $display("FAIL async_comb_lit got=%h exp=00000004", shiftedGenericOutput);
        end
        // Edges while held in reset must not capture.
        inValid = 1'b1;
        genericInput = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check_regs("async_held");
        inValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(32'h0000_0010, 1'b1, 1'b0);
        check_regs("async_first_capture");
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        genericInput = '0;
        inValid      = 1'b0;
        clearSticky  = 1'b0;
        test_reset();
        test_comb_directed();
        test_registered_flow();
        test_random_stream(300);
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
